// File: rtl/cam_serial_tx.sv
// Bit-serial camera-line transmitter: accepts PIX_W-bit pixels over valid/ready
// and sends one IMG_W x IMG_H frame as start(1) / data MSB-first / stop(0) symbols.
module cam_serial_tx #(
  parameter int PIX_W   = 8,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int CLK_DIV = 425,
  parameter int CNT_W   = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [PIX_W-1:0] i_pix_data,
  input  logic             i_pix_valid,
  output logic             o_pix_ready,
  output logic             o_cam_data,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_pix_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PIX_W - 1);
  localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(IMG_W * IMG_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [PIX_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cam_q, cam_d;
  logic             period_end;
  logic             timed_state;

  assign period_end  = (div_q == DIV_LAST);
  assign timed_state = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    div_d   = '0;

    // Abort overrides every transition outside IDLE; the count is left intact.
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            state_d = S_LOAD;
            cnt_d   = '0;
          end
        end
        S_LOAD: begin
          if (i_pix_valid) begin
            shreg_d = i_pix_data;
            cnt_d   = cnt_q + 1'b1;
            state_d = S_START;
          end
        end
        S_START: begin
          if (period_end) begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
        S_DATA: begin
          if (period_end) begin
            if (bit_q == BIT_LAST) begin
              state_d = S_STOP;
            end else begin
              shreg_d = shreg_q << 1;
              bit_d   = bit_q + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (period_end) begin
            state_d = (cnt_q == PIX_TOTAL) ? S_DONE : S_LOAD;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Divider restarts on every state entry and on every bit boundary.
    if (timed_state && (state_d == state_q) && !period_end) begin
      div_d = div_q + 1'b1;
    end

    // Line level is derived from the next state so the output register lines up with it.
    cam_d = (state_d == S_START) || ((state_d == S_DATA) && shreg_d[PIX_W-1]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      cam_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      cam_q   <= cam_d;
    end
  end

  // Pixel payload needs no reset: it only reaches the line after a handshake reloads it.
  always_ff @(posedge i_clk) begin
    shreg_q <= shreg_d;
  end

  assign o_pix_ready  = (state_q == S_LOAD);
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = (state_q == S_DONE);
  assign o_cam_data   = cam_q;
  assign o_pix_cnt    = cnt_q;

endmodule

// File: doc/cam_serial_tx.md
# cam_serial_tx

Bit-serial camera-line transmitter: the sending end of the single-wire `i_cam_data` protocol consumed by the accelerator input stage. It takes 8-bit pixels from a valid/ready source (image ROM, testbench, or host bridge) and serializes one full IMG_W×IMG_H frame onto `o_cam_data`, one bit every CLK_DIV clock cycles. It sits on the 200 MHz domain and drives the accelerator's camera pin in emulation and board-level bring-up.

## Interface
- PIX_W, 8: pixel width in bits.
- IMG_W, 28: pixels per row.
- IMG_H, 28: rows per frame.
- CLK_DIV, 425: clock cycles per serial bit (200 MHz / 425 ≈ 470 kHz); must be ≥2.
- CNT_W, 10: width of the pixel counter; must satisfy 2^CNT_W > IMG_W*IMG_H.

Ports:
- i_clk  in  1  system clock, 200 MHz.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_start  in  1  one-cycle pulse; starts a frame when idle.
- i_abort  in  1  synchronous abort; stops the frame at once.
- i_pix_data  in  PIX_W  pixel to send.
- i_pix_valid  in  1  i_pix_data is valid.
- o_pix_ready  out  1  block can accept a pixel this cycle.
- o_cam_data  out  1  serial line.
- o_busy  out  1  high while a frame is in progress.
- o_frame_done  out  1  one-cycle pulse after the last stop bit.
- o_pix_cnt  out  CNT_W  pixels accepted in the current or last frame.

## Operation
- Line format: idle level 0. Each pixel is sent as one start bit (1), then PIX_W data bits MSB first, then one stop bit (0). The line stays 0 between pixels.
- FSM states: IDLE, LOAD, START, DATA, STOP, DONE.
  - IDLE: `i_start` moves to LOAD and clears `o_pix_cnt` to 0.
  - LOAD: `o_pix_ready`=1, driven combinationally from the state. On `i_pix_valid`, latch the pixel into the shift register, increment `o_pix_cnt`, and move to START. With no valid pixel the FSM waits indefinitely with the line at 0.
  - START: drive 1 for CLK_DIV cycles, then move to DATA.
  - DATA: drive shreg[PIX_W-1] and shift left every CLK_DIV cycles. The bit counter runs from 0 to PIX_W-1; after the last bit, move to STOP.
  - STOP: drive 0 for CLK_DIV cycles. If `o_pix_cnt` == IMG_W*IMG_H, move to DONE; otherwise move to LOAD.
  - DONE: pulse `o_frame_done` for one cycle, then move to IDLE.
- Bit-period divider: counts 0..CLK_DIV-1 and resets on every state entry, so every bit is exactly CLK_DIV cycles.
- `o_busy` = (state != IDLE).
- `o_pix_cnt` holds its final value after DONE until the next `i_start`.
- `i_start` is ignored outside IDLE.
- `i_abort` has priority over all transitions in every non-IDLE state. It moves the FSM to IDLE on the next edge, forces the line to 0, does not pulse `o_frame_done`, and leaves `o_pix_cnt` holding its value.
- `i_start` and `i_abort` asserted together in IDLE: abort wins, and the FSM stays IDLE.
- `o_cam_data` is registered, with no glitches.

## Timing
- Reset values: `o_cam_data`=0, `o_pix_ready`=0, `o_busy`=0, `o_frame_done`=0, `o_pix_cnt`=0, state=IDLE.
- Start latency: `i_start` is sampled at edge t. At t+1 the FSM is in LOAD, and `o_busy`=1 and `o_pix_ready`=1.
- Pixel latency: a handshake (valid&ready) sampled at edge t makes `o_cam_data`=1 from t+1 for CLK_DIV cycles.
- Bit k (MSB = k=0) starts at t+1+(k+1)*CLK_DIV. The stop bit starts at t+1+(PIX_W+1)*CLK_DIV.
- Minimum pixel period with a continuously valid source: (PIX_W+2)*CLK_DIV+1 cycles. The extra cycle is the LOAD handshake, during which the line is 0.
- `o_frame_done` rises one cycle after the last stop bit ends; `o_busy` falls one cycle after that.
- Minimum frame time: N*((PIX_W+2)*CLK_DIV+1)+2 cycles, where N = IMG_W*IMG_H.

## Test plan
Bench parameters: CLK_DIV=4, IMG_W=2, IMG_H=2.

- Reset mid-frame (assert `i_rst_n`=0 during DATA) -> all outputs return to their reset values immediately and asynchronously; the line is 0.
- `i_start`, then pixels 0xA5, 0x00, 0xFF, 0x3C with valid always high -> line carries 1,1,0,1,0,0,1,0,1,0 for 0xA5, each bit 4 cycles. `o_frame_done` pulses once after 4 pixels; `o_pix_cnt`=4; total frame time 4*41+2=166 cycles.
- Valid withheld for 20 cycles before pixel 2 -> line stays 0 for the gap, `o_pix_ready` stays 1, and no bit is corrupted.
- `i_start` pulsed during DATA -> ignored; frame and `o_pix_cnt` are unaffected.
- `i_abort` asserted in DATA of pixel 2 -> next cycle `o_busy`=0 and line=0, no `o_frame_done` pulse, `o_pix_cnt`=2. A subsequent `i_start` runs a clean full frame.
- Loopback through the accelerator input stage with a known 28×28 image at CLK_DIV=425 -> receiver reassembles bytes identical to the source image.
